// File: rtl/snitch_icache_l0_perf_cnt.sv
// Saturating per-event-type counters summed over all L0 fetch ports.
// Two pipeline stages (capture, then accumulate) and a registered read port.
module snitch_icache_l0_perf_cnt #(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned COUNTER_WIDTH  = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic                                clear_i,
  // Per port, bit e is event type e: 0 miss, 1 hit, 2 prefetch, 3 double_hit, 4 stall.
  input  logic [NR_FETCH_PORTS-1:0][4:0]      events_i,
  input  logic                                rd_req_i,
  input  logic [2:0]                          rd_addr_i,
  output logic                                rd_gnt_o,
  output logic                                rd_rvalid_o,
  output logic [COUNTER_WIDTH-1:0]            rd_rdata_o
);

  localparam int unsigned NR_EVENTS = 5;
  localparam int unsigned INC_W     = $clog2(NR_FETCH_PORTS + 1);

  logic [NR_FETCH_PORTS-1:0][4:0]              ev_q;
  logic [NR_EVENTS-1:0][COUNTER_WIDTH-1:0]     cnt_all;
  logic [NR_EVENTS-1:0]                        ovf_all;
  logic [COUNTER_WIDTH-1:0]                    rd_mux;

  // Disabled or cleared cycles capture nothing, so their events never reach a counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ev_q <= '0;
    end else if (clear_i || !enable_i) begin
      ev_q <= '0;
    end else begin
      ev_q <= events_i;
    end
  end

  for (genvar gi = 0; gi < NR_EVENTS; gi++) begin : g_cnt
    logic [INC_W-1:0]         inc;
    logic [COUNTER_WIDTH:0]   sum;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic                     ovf_q;

    always_comb begin
      inc = '0;
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        inc = inc + INC_W'(ev_q[p][gi]);
      end
    end

    assign sum = {1'b0, cnt_q} + (COUNTER_WIDTH + 1)'(inc);

    // The carry-out saturates; an all-ones counter keeps carrying, so it stays put.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (clear_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (sum[COUNTER_WIDTH]) begin
        cnt_q <= '1;
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= sum[COUNTER_WIDTH-1:0];
      end
    end

    assign cnt_all[gi] = cnt_q;
    assign ovf_all[gi] = ovf_q;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr_i)
      3'd0:    rd_mux = cnt_all[0];
      3'd1:    rd_mux = cnt_all[1];
      3'd2:    rd_mux = cnt_all[2];
      3'd3:    rd_mux = cnt_all[3];
      3'd4:    rd_mux = cnt_all[4];
      3'd5:    rd_mux = COUNTER_WIDTH'(ovf_all);
      default: rd_mux = '0;
    endcase
  end

  assign rd_gnt_o = rd_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_rvalid_o <= 1'b0;
      rd_rdata_o  <= '0;
    end else begin
      rd_rvalid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_rdata_o <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_snitch_icache_l0_perf_cnt.sv
// Directed bench for snitch_icache_l0_perf_cnt with 4 ports and 8-bit counters.
module tb_snitch_icache_l0_perf_cnt;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            clear;
  logic [3:0][4:0] events;
  logic            rd_req;
  logic [2:0]      rd_addr;
  logic            rd_gnt;
  logic            rd_rvalid;
  logic [7:0]      rd_rdata;

  int total = 0;
  int bad   = 0;

  snitch_icache_l0_perf_cnt #(
    .NR_FETCH_PORTS(4),
    .COUNTER_WIDTH (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .clear_i    (clear),
    .events_i   (events),
    .rd_req_i   (rd_req),
    .rd_addr_i  (rd_addr),
    .rd_gnt_o   (rd_gnt),
    .rd_rvalid_o(rd_rvalid),
    .rd_rdata_o (rd_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle read; returns what the port shows one edge later.
  task automatic rd(input logic [2:0] a, output logic v, output logic [7:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    v = rd_rvalid;
    d = rd_rdata;
    rd_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    events = '0;
    rd_req = 1'b1;
    rd_addr = 3'd0;
    #2;
    total++;
    if (rd_gnt !== 1'b1) begin bad++; $display("FAIL reset_gnt_follows got=%b want=1", rd_gnt); end
    total++;
    if (rd_rvalid !== 1'b0 || rd_rdata !== 8'd0) begin
      bad++; $display("FAIL reset_outputs got=%b/%0d want=0/0", rd_rvalid, rd_rdata);
    end
    rd_req = 1'b0;
    #1;
    total++;
    if (rd_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_low got=%b want=0", rd_gnt); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) begin
      logic v; logic [7:0] d;
      rd(3'(a), v, d);
      total++;
      if (v !== 1'b1 || d !== 8'd0) begin
        bad++; $display("FAIL reset_read_a%0d got=%b/%0d want=1/0", a, v, d);
      end
      $display("reset read addr=%0d valid=%b data=%0d", a, v, d);
    end
  endtask

  task automatic test_single_hit();
    logic v; logic [7:0] d;
    events[0] = 5'b00010;
    tick();                 // t: captured at this edge
    events = '0;
    tick();                 // t+1: counter updates at this edge
    total++;
    if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL single_hit_idle got=%b want=0", rd_rvalid); end
    rd(3'd1, v, d);         // issued in t+2, valid in t+3
    total++;
    if (v !== 1'b1 || d !== 8'd1) begin bad++; $display("FAIL single_hit_a1 got=%b/%0d want=1/1", v, d); end
    $display("single_hit read addr=1 valid=%b data=%0d", v, d);
    for (int a = 0; a < 5; a++) begin
      if (a != 1) begin
        rd(3'(a), v, d);
        total++;
        if (d !== 8'd0) begin bad++; $display("FAIL single_hit_a%0d got=%0d want=0", a, d); end
        $display("single_hit read addr=%0d data=%0d", a, d);
      end
    end
  endtask

  task automatic test_all_events();
    logic v; logic [7:0] d;
    do_clear();
    events = {4{5'h1f}};
    repeat (10) tick();
    events = '0;
    repeat (2) tick();
    // Back-to-back: one read per cycle across all counters and the overflow mask.
    for (int a = 0; a < 6; a++) begin
      logic [7:0] exp;
      exp = (a == 5) ? 8'd0 : 8'd40;
      rd(3'(a), v, d);
      total++;
      if (v !== 1'b1 || d !== exp) begin
        bad++; $display("FAIL all_events_a%0d got=%b/%0d want=1/%0d", a, v, d, exp);
      end
      $display("all_events read addr=%0d valid=%b data=%0d", a, v, d);
    end
    tick();
    total++;
    if (rd_rvalid !== 1'b0 || rd_rdata !== 8'd0) begin
      bad++; $display("FAIL rdata_hold got=%b/%0d want=0/0", rd_rvalid, rd_rdata);
    end
  endtask

  task automatic test_saturation();
    logic v; logic [7:0] d;
    do_clear();
    events = {4{5'b00001}};
    repeat (63) tick();
    events = '0;
    repeat (2) tick();
    rd(3'd0, v, d);
    total++;
    if (d !== 8'd252) begin bad++; $display("FAIL sat_pre got=%0d want=252", d); end
    $display("saturation read addr=0 data=%0d", d);
    rd(3'd5, v, d);
    total++;
    if (d !== 8'd0) begin bad++; $display("FAIL sat_pre_mask got=%0d want=0", d); end
    events = {4{5'b00001}};
    tick();
    events = '0;
    repeat (2) tick();
    rd(3'd0, v, d);
    total++;
    if (d !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", d); end
    $display("saturation read addr=0 data=%0d", d);
    rd(3'd5, v, d);
    total++;
    if (d !== 8'd1) begin bad++; $display("FAIL sat_mask got=%0d want=1", d); end
    events = {4{5'b00001}};
    repeat (3) tick();
    events = '0;
    repeat (2) tick();
    rd(3'd0, v, d);
    total++;
    if (d !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", d); end
    $display("saturation hold read addr=0 data=%0d", d);
  endtask

  // Runs with the miss overflow still set from the saturation test.
  task automatic test_clear_vs_events();
    logic v; logic [7:0] d;
    events = {4{5'b10000}};
    tick();
    events = {1'b0, {3{5'b10000}}} == '0 ? '0 : {5'b00000, {3{5'b10000}}};
    tick();
    events = '0;
    repeat (2) tick();
    rd(3'd4, v, d);
    total++;
    if (d !== 8'd7) begin bad++; $display("FAIL clr_setup got=%0d want=7", d); end
    events[0] = 5'b10000;
    tick();                 // this stall now sits in the capture stage
    clear   = 1'b1;
    rd_req  = 1'b1;
    rd_addr = 3'd4;
    tick();
    clear  = 1'b0;
    rd_req = 1'b0;
    total++;
    if (rd_rvalid !== 1'b1 || rd_rdata !== 8'd7) begin
      bad++; $display("FAIL clr_same_cycle got=%b/%0d want=1/7", rd_rvalid, rd_rdata);
    end
    $display("clear same-cycle read addr=4 data=%0d", rd_rdata);
    events = '0;
    events[1] = 5'b10000;   // first cycle after clear is counted
    tick();
    events = '0;
    repeat (2) tick();
    rd(3'd4, v, d);
    total++;
    if (d !== 8'd1) begin bad++; $display("FAIL clr_after got=%0d want=1", d); end
    rd(3'd5, v, d);
    total++;
    if (d !== 8'd0) begin bad++; $display("FAIL clr_mask got=%0d want=0", d); end
    rd(3'd0, v, d);
    total++;
    if (d !== 8'd0) begin bad++; $display("FAIL clr_miss got=%0d want=0", d); end
    $display("clear after reads stall/mask/miss done last=%0d", d);
  endtask

  task automatic test_enable();
    logic v; logic [7:0] d;
    do_clear();
    enable = 1'b0;
    events = '0;
    events[0] = 5'b00100;
    events[1] = 5'b00100;
    tick();
    enable = 1'b1;
    events[2] = 5'b00100;
    tick();
    events = '0;
    repeat (2) tick();
    rd(3'd2, v, d);
    total++;
    if (d !== 8'd3) begin bad++; $display("FAIL enable_gate got=%0d want=3", d); end
    $display("enable read addr=2 data=%0d", d);
    events[3] = 5'b00100;
    tick();
    events = '0;
    enable = 1'b0;          // already captured, still counted
    repeat (2) tick();
    enable = 1'b1;
    rd(3'd2, v, d);
    total++;
    if (d !== 8'd4) begin bad++; $display("FAIL enable_inflight got=%0d want=4", d); end
    $display("enable inflight read addr=2 data=%0d", d);
  endtask

  task automatic test_reset_mid_and_reserved();
    logic v; logic [7:0] d;
    events  = {4{5'h1f}};
    rd_req  = 1'b1;
    rd_addr = 3'd2;
    tick();
    total++;
    if (rd_rvalid !== 1'b1 || rd_rdata !== 8'd4) begin
      bad++; $display("FAIL midrst_pre got=%b/%0d want=1/4", rd_rvalid, rd_rdata);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rd_rvalid !== 1'b0 || rd_rdata !== 8'd0) begin
      bad++; $display("FAIL midrst_async got=%b/%0d want=0/0", rd_rvalid, rd_rdata);
    end
    $display("mid reset valid=%b data=%0d", rd_rvalid, rd_rdata);
    rd_req = 1'b0;
    events = '0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v, d);
      total++;
      if (d !== 8'd0) begin bad++; $display("FAIL midrst_a%0d got=%0d want=0", a, d); end
    end
    events = {4{5'h1f}};
    tick();
    events = '0;
    repeat (2) tick();
    rd(3'd0, v, d);
    total++;
    if (d !== 8'd4) begin bad++; $display("FAIL reserved_setup got=%0d want=4", d); end
    for (int a = 6; a < 8; a++) begin
      rd(3'(a), v, d);
      total++;
      if (v !== 1'b1 || d !== 8'd0) begin
        bad++; $display("FAIL reserved_a%0d got=%b/%0d want=1/0", a, v, d);
      end
      $display("reserved read addr=%0d valid=%b data=%0d", a, v, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_all_events();
    test_saturation();
    test_clear_vs_events();
    test_enable();
    test_reset_mid_and_reserved();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snitch_icache_l0_perf_cnt.md
# snitch_icache_l0_perf_cnt

Performance-counter sink for the L0 event vectors (`icache_l0_events_t`) emitted by every fetch port's L0 cache. Per event type, it sums the events across all ports into saturating counters. It exposes the counters through a single-cycle-latency read port. It sits beside the icache root, and its read port is wired into the cluster peripheral register file.

## Interface
Parameters:
- `NR_FETCH_PORTS`, default 4: number of L0 event vectors observed; must be ≥1.
- `COUNTER_WIDTH`, default 32: width of each counter; must be 8..63.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `enable_i`, in, 1: count enable. Events presented while this is low are discarded.
- `clear_i`, in, 1: synchronous clear of all counters, overflow flags and the pipeline stage.
- `events_i`, in, `NR_FETCH_PORTS` × `icache_l0_events_t`: per-port event pulses, one cycle each.
- `rd_req_i`, in, 1: read request.
- `rd_addr_i`, in, 3: counter select. 0 = miss, 1 = hit, 2 = prefetch, 3 = double_hit, 4 = stall, 5 = overflow mask, 6..7 reserved.
- `rd_gnt_o`, out, 1: read grant. Combinationally equal to `rd_req_i`.
- `rd_rvalid_o`, out, 1: read data valid.
- `rd_rdata_o`, out, `COUNTER_WIDTH`: read data.

## Operation
- **Capture stage.** Each cycle, `ev_q[p] <= enable_i ? events_i[p] : '0`. If `clear_i` is high, `ev_q <= '0` instead.
- **Increment.** For each event type e, `inc_e = popcount(ev_q[*].e)`. The increment is `$clog2(NR_FETCH_PORTS+1)` bits wide and zero-extended.
- **Accumulate.** Compute `sum = cnt_e + inc_e` in `COUNTER_WIDTH+1` bits.
  - If `sum[COUNTER_WIDTH]` is set, `cnt_e <= '1` (all ones) and `ovf_q[e] <= 1`.
  - Otherwise `cnt_e <= sum[COUNTER_WIDTH-1:0]`.
  - A counter at all ones stays at all ones, and its overflow flag is sticky.
- **Clear.** `clear_i` has priority over accumulation.
  - In the cycle `clear_i` is high, all `cnt_e` and `ovf_q` are set to 0.
  - The `ev_q` contents of that cycle are dropped.
- **Read.**
  - A read is accepted whenever `rd_req_i` is high; there is no back-pressure.
  - `rd_rdata_o` registers the value of the selected counter as it is before the current edge's update.
  - Address 5 returns `{'0, ovf_q[4:0]}`, with bit e corresponding to address e.
  - Addresses 6 and 7 return 0.
  - `rd_rvalid_o <= rd_req_i`.
  - When `rd_rvalid_o` is 0, `rd_rdata_o` holds its last value.
- **No state machine.** The block is a 2-stage pipeline (capture, then accumulate) plus a registered read mux.

## Timing
- **Reset values.** `rst_ni` low asynchronously clears `ev_q`, all counters, `ovf_q`, `rd_rvalid_o` and `rd_rdata_o` to 0. `rd_gnt_o` follows `rd_req_i` during reset.
- **Event-to-counter latency.** An event on `events_i` in cycle t is captured at the end of t. The counter changes at the end of t+1. A read issued in t+2 returns the updated value with `rd_rvalid_o` high in t+3.
- **Read latency.** Exactly 1 cycle, and back-to-back reads are supported at one per cycle.
- **Read coinciding with an update or clear.** A read in the same cycle as an update or a clear returns the pre-update value.
- **Clear followed by events.** With `clear_i` in t and `events_i` in t, the counter is 0 at the end of t and those events are lost. Events in t+1 are counted normally.
- **Enable.** Toggling `enable_i` affects only events presented in the same cycle. Events already in `ev_q` are still counted.
- **Reset mid-operation.** Reset drops any in-flight events and any pending `rd_rvalid_o`.

## Test plan
- **Single hit.** After reset, pulse `hit` on port 0 for 1 cycle with `enable_i=1`. Read address 1 in t+2 → `rd_rvalid_o=1` in t+3 with data 1. Reads of addresses 0, 2, 3 and 4 return 0.
- **All ports, all events.** With `NR_FETCH_PORTS=4`, assert all 5 event bits on all 4 ports for 10 cycles. Every counter reads 40, and address 5 reads 0.
- **Saturation.** Use `COUNTER_WIDTH=8`, with `miss` high on all 4 ports for 64 cycles, then 1 more cycle. Counter 0 reads 255 (not 0 or 4), and address 5 reads 5'b00001. Further misses keep it at 255.
- **Clear versus events.** Set stall=7 on the counter. Assert `clear_i` in the same cycle as a stall event in `ev_q` and another on `events_i`. A read in that cycle returns 7. A later read returns 0, and the overflow mask is 0.
- **Enable gating.** With `enable_i=0`, pulse `prefetch` on 2 ports. Then raise `enable_i` and pulse `prefetch` on 3 ports. Counter 2 reads 3.
- **Async reset and reserved addresses.**
  - Assert `rst_ni` low mid-stream while a read is pending. `rd_rvalid_o` is 0 immediately, and all counters read 0 after release.
  - Reads of addresses 6 and 7 return 0 with `rd_rvalid_o=1`.
